// File: rtl/priority_scanner_pkg.sv
// Shared constants for priority_scanner: FSM state encoding, scan direction, popcount helper.
package priority_scanner_pkg;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

   // Width-agnostic popcount; callers zero-extend to 64 bits.
   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/ps_bit_find.sv
// Combinational finder: lowest (LSB-first) or highest (MSB-first) set bit of a word.
module ps_bit_find
   import priority_scanner_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] word,
   input  logic             dir,
   output logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] index,
   output logic             single
);

   logic found;

   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (dir == DIR_MSB) begin
            if (word[i]) index = IDX_W'(i);
         end else if (word[i] && !found) begin
            index = IDX_W'(i);
            found = 1'b1;
         end
      end
      onehot = (word != '0) ? (WIDTH'(1) << index) : '0;
      single = (word != '0) && ((word & (word - WIDTH'(1))) == '0);
   end

endmodule

// File: rtl/priority_scanner.sv
// Serialises the set bits of an accepted word into one-hot beats with ready/valid handshakes.
// Optional beat counters are enabled by defining PRIORITY_SCANNER_COUNT_EN.
module priority_scanner
   import priority_scanner_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             dir_i,
   input  logic             data_val_i,
   output logic             data_ready_o,
   output logic [WIDTH-1:0] onehot_o,
   output logic [IDX_W-1:0] index_o,
   output logic             last_o,
   output logic             zero_o,
   input  logic             onehot_ready_i,
   output logic             onehot_val_o
`ifdef PRIORITY_SCANNER_COUNT_EN
   ,
   output logic [IDX_W:0]   beat_num_o,
   output logic [IDX_W:0]   beat_total_o
`endif
);

   localparam int unsigned CNT_W = IDX_W + 1;

   logic [0:0]       state, state_nxt;
   logic [WIDTH-1:0] resid, resid_nxt;
   logic             dir_q, dir_nxt;
   logic             accept, consume;
   logic [WIDTH-1:0] f_onehot, onehot_nxt;
   logic [IDX_W-1:0] f_index, index_nxt;
   logic             f_single;
   logic             val_nxt, last_nxt, zero_nxt, ready_nxt;

   // Finder looks at the next residual so every beat output can be a flop.
   ps_bit_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find (
      .word   (resid_nxt),
      .dir    (dir_nxt),
      .onehot (f_onehot),
      .index  (f_index),
      .single (f_single)
   );

   always_comb begin
      state_nxt = state;
      resid_nxt = resid;
      dir_nxt   = dir_q;
      accept    = data_ready_o && data_val_i;
      consume   = onehot_val_o && onehot_ready_i;
      case (state)
         IDLE: if (accept) begin
            state_nxt = SCAN;
            resid_nxt = data_i;
            dir_nxt   = dir_i;
         end
         SCAN: if (consume) begin
            resid_nxt = resid & ~onehot_o;
            if (last_o) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      val_nxt    = (state_nxt == SCAN);
      ready_nxt  = (state_nxt == IDLE);
      onehot_nxt = val_nxt ? f_onehot : '0;
      index_nxt  = val_nxt ? f_index : '0;
      // A zero word is its own single, final beat.
      last_nxt   = val_nxt && (f_single || (resid_nxt == '0));
      zero_nxt   = accept ? (data_i == '0) : (val_nxt && zero_o);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state        <= IDLE;
         resid        <= '0;
         dir_q        <= DIR_LSB;
         data_ready_o <= 1'b1;
         onehot_val_o <= 1'b0;
         onehot_o     <= '0;
         index_o      <= '0;
         last_o       <= 1'b0;
         zero_o       <= 1'b0;
      end else begin
         state        <= state_nxt;
         resid        <= resid_nxt;
         dir_q        <= dir_nxt;
         data_ready_o <= ready_nxt;
         onehot_val_o <= val_nxt;
         onehot_o     <= onehot_nxt;
         index_o      <= index_nxt;
         last_o       <= last_nxt;
         zero_o       <= zero_nxt;
      end
   end

`ifdef PRIORITY_SCANNER_COUNT_EN
   logic [CNT_W-1:0] num_nxt, total_nxt;
   logic [6:0]       pc;

   always_comb begin
      pc = popcount64(64'(data_i));
      if (accept) begin
         num_nxt   = CNT_W'(1);
         total_nxt = (data_i == '0) ? CNT_W'(1) : CNT_W'(pc);
      end else if (val_nxt) begin
         num_nxt   = consume ? beat_num_o + CNT_W'(1) : beat_num_o;
         total_nxt = beat_total_o;
      end else begin
         num_nxt   = '0;
         total_nxt = '0;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         beat_num_o   <= '0;
         beat_total_o <= '0;
      end else begin
         beat_num_o   <= num_nxt;
         beat_total_o <= total_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_priority_scanner.sv
// Directed self-checking bench for priority_scanner (WIDTH=16).
module tb_priority_scanner;

   logic        clk_i = 1'b0;
   logic        arst_i;
   logic [15:0] data_i;
   logic        dir_i;
   logic        data_val_i;
   logic        data_ready_o;
   logic [15:0] onehot_o;
   logic [3:0]  index_o;
   logic        last_o;
   logic        zero_o;
   logic        onehot_ready_i;
   logic        onehot_val_o;
`ifdef PRIORITY_SCANNER_COUNT_EN
   logic [4:0]  beat_num_o;
   logic [4:0]  beat_total_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   priority_scanner #(.WIDTH(16)) dut (
      .clk_i          (clk_i),
      .arst_i         (arst_i),
      .data_i         (data_i),
      .dir_i          (dir_i),
      .data_val_i     (data_val_i),
      .data_ready_o   (data_ready_o),
      .onehot_o       (onehot_o),
      .index_o        (index_o),
      .last_o         (last_o),
      .zero_o         (zero_o),
      .onehot_ready_i (onehot_ready_i),
      .onehot_val_o   (onehot_val_o)
`ifdef PRIORITY_SCANNER_COUNT_EN
      ,
      .beat_num_o     (beat_num_o),
      .beat_total_o   (beat_total_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [15:0] oh,
                           input logic lst, input logic zr);
      chk({tag, ".val"},    64'(onehot_val_o), 64'(1));
      chk({tag, ".rdy"},    64'(data_ready_o), 64'(0));
      chk({tag, ".index"},  64'(index_o), 64'(idx));
      chk({tag, ".onehot"}, 64'(onehot_o), 64'(oh));
      chk({tag, ".last"},   64'(last_o), 64'(lst));
      chk({tag, ".zero"},   64'(zero_o), 64'(zr));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".val"}, 64'(onehot_val_o), 64'(0));
      chk({tag, ".rdy"}, 64'(data_ready_o), 64'(1));
   endtask

   task automatic send(input logic [15:0] d, input logic dr);
      data_i     = d;
      dir_i      = dr;
      data_val_i = 1'b1;
      step();
      data_val_i = 1'b0;
   endtask

   initial begin
      arst_i         = 1'b1;
      data_i         = '0;
      dir_i          = 1'b0;
      data_val_i     = 1'b0;
      onehot_ready_i = 1'b1;
      #12;
      chk("reset.rdy",    64'(data_ready_o), 64'(1));
      chk("reset.val",    64'(onehot_val_o), 64'(0));
      chk("reset.onehot", 64'(onehot_o), 64'(0));
      chk("reset.index",  64'(index_o), 64'(0));
      chk("reset.last",   64'(last_o), 64'(0));
      chk("reset.zero",   64'(zero_o), 64'(0));
      step();
      arst_i = 1'b0;
      step();
      chk_idle("post_reset");

      // 0x8421 LSB-first: bits 0,5,10,15
      send(16'h8421, 1'b0);
      chk_beat("lsb0", 0,  16'h0001, 1'b0, 1'b0); step();
      chk_beat("lsb1", 5,  16'h0020, 1'b0, 1'b0); step();
      chk_beat("lsb2", 10, 16'h0400, 1'b0, 1'b0); step();
      chk_beat("lsb3", 15, 16'h8000, 1'b1, 1'b0); step();
      chk_idle("lsb_done");

      // MSB-first; dir_i flipped and data_val_i held during SCAN must be ignored
      send(16'h8421, 1'b1);
      dir_i = 1'b0; data_i = 16'hFFFF; data_val_i = 1'b1;
      chk_beat("msb0", 15, 16'h8000, 1'b0, 1'b0); step();
      chk_beat("msb1", 10, 16'h0400, 1'b0, 1'b0); step();
      chk_beat("msb2", 5,  16'h0020, 1'b0, 1'b0); step();
      chk_beat("msb3", 0,  16'h0001, 1'b1, 1'b0);
      data_val_i = 1'b0;
      step();
      chk_idle("msb_done");

      // all-zero word: single zero beat
      send(16'h0000, 1'b0);
      chk_beat("zero0", 0, 16'h0000, 1'b1, 1'b1); step();
      chk_idle("zero_done");

      // backpressure holds the first beat stable
      onehot_ready_i = 1'b0;
      send(16'h0003, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk_beat("hold", 0, 16'h0001, 1'b0, 1'b0);
         step();
      end
      chk_beat("hold_end", 0, 16'h0001, 1'b0, 1'b0);
      onehot_ready_i = 1'b1;
      step();
      chk_beat("bp1", 1, 16'h0002, 1'b1, 1'b0); step();
      chk_idle("bp_done");

      // reset in mid-scan discards remaining beats
      send(16'hFFFF, 1'b0);
      chk_beat("rst0", 0, 16'h0001, 1'b0, 1'b0); step();
      chk_beat("rst1", 1, 16'h0002, 1'b0, 1'b0); step();
      chk_beat("rst2", 2, 16'h0004, 1'b0, 1'b0); step();
      arst_i = 1'b1;
      #1;
      chk_idle("rst_async");
      chk("rst_async.onehot", 64'(onehot_o), 64'(0));
      chk("rst_async.index",  64'(index_o), 64'(0));
      chk("rst_async.last",   64'(last_o), 64'(0));
      step();
      arst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_idle("rst_after");
      end

`ifdef PRIORITY_SCANNER_COUNT_EN
      // 0x0107: bits 0,1,2,8
      send(16'h0107, 1'b0);
      chk_beat("cnt0", 0, 16'h0001, 1'b0, 1'b0);
      chk("cnt0.num", 64'(beat_num_o), 64'(1));
      chk("cnt0.tot", 64'(beat_total_o), 64'(4));
      step();
      chk_beat("cnt1", 1, 16'h0002, 1'b0, 1'b0);
      chk("cnt1.num", 64'(beat_num_o), 64'(2));
      chk("cnt1.tot", 64'(beat_total_o), 64'(4));
      step();
      chk_beat("cnt2", 2, 16'h0004, 1'b0, 1'b0);
      chk("cnt2.num", 64'(beat_num_o), 64'(3));
      chk("cnt2.tot", 64'(beat_total_o), 64'(4));
      step();
      chk_beat("cnt3", 8, 16'h0100, 1'b1, 1'b0);
      chk("cnt3.num", 64'(beat_num_o), 64'(4));
      chk("cnt3.tot", 64'(beat_total_o), 64'(4));
      step();
      chk_idle("cnt_done");
      send(16'h0000, 1'b0);
      chk("cntz.num", 64'(beat_num_o), 64'(1));
      chk("cntz.tot", 64'(beat_total_o), 64'(1));
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
